// File: rtl/frac_avg.sv
// Block averager for fractional TDC codes: sums 2^AVG_LOG2 samples per channel.
// Optional FRAC_AVG_ROUND_EN selects round-half-up (saturated) averaging.
module frac_avg #(
    parameter int CTR_NUM  = 1,
    parameter int AVG_LOG2 = 4
) (
    input  logic                  clocks,
    input  logic                  rst,
    input  logic [6:0]            in_data [CTR_NUM],
    input  logic                  in_valid,
    input  logic                  restart,
    input  logic                  clr_ovr,
    output logic [6+AVG_LOG2:0]   out_sum [CTR_NUM],
    output logic [6:0]            out_avg [CTR_NUM],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic [AVG_LOG2-1:0]   fill
);

    localparam int SW = 7 + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] FILL_LAST = {AVG_LOG2{1'b1}};

    typedef enum logic {
        ST_EMPTY,
        ST_ACC
    } state_t;

    state_t              state_q, state_d;
    logic [AVG_LOG2-1:0] fill_q, fill_d;
    logic [SW-1:0]       acc_q [CTR_NUM];
    logic [SW-1:0]       acc_d [CTR_NUM];
    logic [SW-1:0]       res   [CTR_NUM];
    logic [6:0]          avg_d [CTR_NUM];
    logic                done;

    logic [SW-1:0]       sum_q [CTR_NUM];
    logic [6:0]          avg_q [CTR_NUM];
    logic                valid_q;
    logic                ovr_q;

`ifdef FRAC_AVG_ROUND_EN
    localparam int HALF = 1 << (AVG_LOG2 - 1);
    logic [SW:0]         rnd [CTR_NUM];
    logic [7:0]          rq  [CTR_NUM];
`endif

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        acc_d   = acc_q;
        done    = 1'b0;
        for (int i = 0; i < CTR_NUM; i++) begin
            res[i] = acc_q[i] + SW'(in_data[i]);
        end
        if (restart) begin
            state_d = ST_EMPTY;
            fill_d  = '0;
            for (int i = 0; i < CTR_NUM; i++) acc_d[i] = '0;
        end else if (in_valid) begin
            unique case (state_q)
                ST_EMPTY: begin
                    state_d = ST_ACC;
                    fill_d  = AVG_LOG2'(1);
                    acc_d   = res;
                end
                ST_ACC: begin
                    if (fill_q == FILL_LAST) begin
                        done    = 1'b1;
                        state_d = ST_EMPTY;
                        fill_d  = '0;
                        for (int i = 0; i < CTR_NUM; i++) acc_d[i] = '0;
                    end else begin
                        fill_d = fill_q + AVG_LOG2'(1);
                        acc_d  = res;
                    end
                end
            endcase
        end
    end

    // Average of the completing block; only consumed when done is high.
    always_comb begin
        for (int i = 0; i < CTR_NUM; i++) begin
`ifdef FRAC_AVG_ROUND_EN
            rnd[i]   = {1'b0, res[i]} + (SW+1)'(HALF);
            rq[i]    = 8'(rnd[i] >> AVG_LOG2);
            avg_d[i] = rq[i][7] ? 7'd127 : rq[i][6:0];
`else
            avg_d[i] = 7'(res[i] >> AVG_LOG2);
`endif
        end
    end

    always_ff @(posedge clocks or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            fill_q  <= '0;
            for (int i = 0; i < CTR_NUM; i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clocks or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CTR_NUM; i++) begin
                sum_q[i] <= '0;
                avg_q[i] <= '0;
            end
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (done) begin
                sum_q   <= res;
                avg_q   <= avg_d;
                valid_q <= 1'b1;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
            // A new overwrite takes precedence over a clear request.
            if (done && valid_q && !out_ready) begin
                ovr_q <= 1'b1;
            end else if (clr_ovr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign out_sum   = sum_q;
    assign out_avg   = avg_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_frac_avg.sv
// Self-checking bench for frac_avg: directed block scenarios plus a
// randomized phase, all compared against a sample-queue reference model.
module tb_frac_avg;

    localparam int CN = 2;
    localparam int AL = 4;
    localparam int N  = 16;
    localparam int SW = 7 + AL;

    logic          clocks = 1'b0;
    logic          rst;
    logic [6:0]    in_data [CN];
    logic          in_valid;
    logic          restart;
    logic          clr_ovr;
    logic [SW-1:0] out_sum [CN];
    logic [6:0]    out_avg [CN];
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic [AL-1:0] fill;

    int n_chk  = 0;
    int n_fail = 0;

    int q0[$];
    int q1[$];
    int e_sum [CN];
    int e_avg [CN];
    bit e_valid;
    bit e_ovr;

    always #5 clocks = ~clocks;

    frac_avg #(.CTR_NUM(CN), .AVG_LOG2(AL)) dut (
        .clocks    (clocks),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .restart   (restart),
        .clr_ovr   (clr_ovr),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .fill      (fill)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int avg_of(input int s);
`ifdef FRAC_AVG_ROUND_EN
        int r;
        r = (s + N / 2) / N;
        return (r > 127) ? 127 : r;
`else
        return s / N;
`endif
    endfunction

    function automatic int qsum(input int q[$]);
        int s = 0;
        foreach (q[k]) s += q[k];
        return s;
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        for (int c = 0; c < CN; c++) begin
            e_sum[c] = 0;
            e_avg[c] = 0;
        end
        e_valid = 0;
        e_ovr   = 0;
    endtask

    task automatic model_edge();
        bit done = 0;
        if (restart) begin
            q0.delete();
            q1.delete();
        end else if (in_valid) begin
            q0.push_back(int'(in_data[0]));
            q1.push_back(int'(in_data[1]));
            if (q0.size() == N) begin
                done = 1;
                e_sum[0] = qsum(q0);
                e_sum[1] = qsum(q1);
                e_avg[0] = avg_of(e_sum[0]);
                e_avg[1] = avg_of(e_sum[1]);
                q0.delete();
                q1.delete();
            end
        end
        if (done && e_valid && !out_ready) e_ovr = 1;
        else if (clr_ovr) e_ovr = 0;
        if (done) e_valid = 1;
        else if (e_valid && out_ready) e_valid = 0;
    endtask

    task automatic compare_all();
        chk("out_valid", out_valid, e_valid);
        chk("overrun", overrun, e_ovr);
        chk("fill", fill, q0.size());
        for (int c = 0; c < CN; c++) begin
            chk($sformatf("out_sum%0d", c), out_sum[c], e_sum[c]);
            chk($sformatf("out_avg%0d", c), out_avg[c], e_avg[c]);
        end
    endtask

    task automatic cyc(input bit v, input int a, input int b);
        in_valid   = v;
        in_data[0] = 7'(a);
        in_data[1] = 7'(b);
        @(posedge clocks);
        model_edge();
        #1;
        compare_all();
        in_valid = 0;
        restart  = 0;
        clr_ovr  = 0;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        compare_all();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 0;
        restart    = 0;
        clr_ovr    = 0;
        out_ready  = 1;
        in_data[0] = '0;
        in_data[1] = '0;
        model_clear();
        #12;
        compare_all();
        rst = 1'b1;

        // Basic average
        for (int k = 0; k < N; k++) cyc(1, 10, 20);
        chk("basic_sum0", out_sum[0], 160);
        chk("basic_sum1", out_sum[1], 320);
        chk("basic_avg0", out_avg[0], 10);
        chk("basic_avg1", out_avg[1], 20);
        chk("basic_valid", out_valid, 1);
        cyc(0, 0, 0);
        chk("basic_drain", out_valid, 0);

        // Rounding boundary: sum 120
        for (int k = 0; k < N; k++) cyc(1, k, 0);
        chk("rnd_sum0", out_sum[0], 120);
`ifdef FRAC_AVG_ROUND_EN
        chk("rnd_avg0", out_avg[0], 8);
`else
        chk("rnd_avg0", out_avg[0], 7);
`endif
        cyc(0, 0, 0);

        // Full scale
        for (int k = 0; k < N; k++) cyc(1, 127, 127);
        chk("fs_sum0", out_sum[0], 2032);
        chk("fs_avg0", out_avg[0], 127);
        cyc(0, 0, 0);

        // Overrun with stalled consumer
        out_ready = 0;
        for (int k = 0; k < N; k++) cyc(1, 1, 1);
        chk("ovr_first", overrun, 0);
        for (int k = 0; k < N; k++) begin
            cyc(1, 2, 2);
            cyc(0, 0, 0);
        end
        chk("ovr_sum0", out_sum[0], 32);
        chk("ovr_flag", overrun, 1);
        chk("ovr_valid", out_valid, 1);
        out_ready = 1;
        cyc(0, 0, 0);
        chk("ovr_drain", out_valid, 0);
        chk("ovr_sticky", overrun, 1);
        clr_ovr = 1;
        cyc(0, 0, 0);
        chk("ovr_clear", overrun, 0);

        // Restart, including one coinciding with a strobe
        for (int k = 0; k < 5; k++) cyc(1, 50, 50);
        restart = 1;
        cyc(1, 50, 50);
        chk("rst_fill", fill, 0);
        for (int k = 0; k < N; k++) cyc(1, 3, 3);
        chk("restart_sum0", out_sum[0], 48);
        chk("restart_avg0", out_avg[0], 3);
        cyc(0, 0, 0);

        // Async reset mid-block with a result pending
        out_ready = 0;
        for (int k = 0; k < N; k++) cyc(1, 5, 6);
        for (int k = 0; k < 9; k++) cyc(1, 9, 9);
        async_reset();
        chk("ar_valid", out_valid, 0);
        chk("ar_sum0", out_sum[0], 0);
        chk("ar_fill", fill, 0);
        out_ready = 1;
        for (int k = 0; k < N; k++) cyc(1, 7, 8);
        chk("ar_sum0_after", out_sum[0], 112);
        chk("ar_sum1_after", out_sum[1], 128);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            restart   = ($urandom_range(0, 59) == 0);
            clr_ovr   = ($urandom_range(0, 29) == 0);
            cyc(($urandom_range(0, 2) != 0),
                int'($urandom_range(0, 127)),
                int'($urandom_range(0, 127)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
